// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when misaligned accesses are trapped.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    MERGE  = 2'b10,
    RESP   = 2'b11
  } lsu_state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Sizes other than byte/half behave as a full word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int dataWidth = 32
) (
  input  logic [1:0]           size_i,
  input  logic                 signed_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [dataWidth-1:0] rdata_i,
  input  logic [dataWidth-1:0] wdata_i,
  input  logic [dataWidth-1:0] merge_i,
  output logic [dataWidth-1:0] load_data_o,
  output logic [dataWidth-1:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_data_o = merge_i;
    case (size_i)
      SZ_BYTE: merge_data_o[{addr_lo_i, 3'b000} +: 8]  = wdata_i[7:0];
      SZ_HALF: merge_data_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_data_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores, sub-word stores by
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32
) (
  input  logic                 CLK,
  input  logic                 Reset_n,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [1:0]           ReqSize,
  input  logic                 ReqSigned,
  input  logic [dataWidth-1:0] ReqAddr,
  input  logic [dataWidth-1:0] ReqWData,
  output logic                 RespValid,
  output logic [dataWidth-1:0] RespData,
  output logic                 RespErr,
  output logic [addWidth-1:0]  MemAddr,
  output logic                 MemWrite,
  output logic [dataWidth-1:0] MemWData,
  input  logic [dataWidth-1:0] MemRData
);

  lsu_state_e           state_q;
  logic                 write_q;
  logic [1:0]           size_q;
  logic                 signed_q;
  logic [addWidth+1:0]  addr_q;
  logic [dataWidth-1:0] wdata_q;
  logic [dataWidth-1:0] merge_q;
  logic                 resp_valid_q;
  logic [dataWidth-1:0] resp_data_q;
  logic                 resp_err_q;

  logic [dataWidth-1:0] load_data_d;
  logic [dataWidth-1:0] merge_data_d;
  logic                 req_mis;
  logic                 unused_addr_hi;

  // Address bits above the word index wrap away by design.
  assign unused_addr_hi = ^ReqAddr[dataWidth-1:addWidth+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = misaligned(ReqSize, ReqAddr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  lsu_lane_align #(
    .dataWidth(dataWidth)
  ) u_align (
    .size_i      (size_q),
    .signed_i    (signed_q),
    .addr_lo_i   (addr_q[1:0]),
    .rdata_i     (MemRData),
    .wdata_i     (wdata_q),
    .merge_i     (merge_q),
    .load_data_o (load_data_d),
    .merge_data_o(merge_data_d)
  );

  assign ReqReady  = (state_q == IDLE);
  assign MemAddr   = addr_q[addWidth+1:2];
  assign MemWData  = (state_q == MERGE) ? merge_data_d : wdata_q;
  // Gated by Reset_n so an abort in the write cycle never reaches memory.
  assign MemWrite  = Reset_n &&
                     ((state_q == ACCESS && write_q && size_q[1]) || state_q == MERGE);
  assign RespValid = resp_valid_q;
  assign RespData  = resp_data_q;
  assign RespErr   = resp_err_q;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ReqValid) begin
            write_q  <= ReqWrite;
            size_q   <= ReqSize;
            signed_q <= ReqSigned;
            addr_q   <= ReqAddr[addWidth+1:0];
            wdata_q  <= ReqWData;
            if (req_mis) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!write_q) begin
            resp_data_q  <= load_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (size_q[1]) begin
            resp_data_q  <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            merge_q <= MemRData;
            state_q <= MERGE;
          end
        end
        MERGE: begin
          resp_data_q  <= '0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-level reference memory and
// per-request timing model checked every cycle, plus literal expectations.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespErr;
  logic [5:0]  MemAddr;
  logic        MemWrite;
  logic [31:0] MemWData;
  logic [31:0] MemRData;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  int errs = 0;
  int checks = 0;

  load_store_unit #(.addWidth(6), .dataWidth(32)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RespValid(RespValid),
    .RespData(RespData), .RespErr(RespErr), .MemAddr(MemAddr),
    .MemWrite(MemWrite), .MemWData(MemWData), .MemRData(MemRData)
  );

  always #5 CLK = ~CLK;

  assign MemRData = mem[MemAddr];
  always @(posedge CLK) if (MemWrite) mem[MemAddr] <= MemWData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b, want %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference semantics of a load / store on one memory word.
  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] lo);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * lo)) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * lo[1])) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_word(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] m;
    if (sz == 2'b00) begin
      m = 32'h0000_00FF << (8 * lo);
      return (w & ~m) | ((d & 32'h0000_00FF) << (8 * lo));
    end else if (sz == 2'b01) begin
      m = 32'h0000_FFFF << (16 * lo[1]);
      return (w & ~m) | ((d & 32'h0000_FFFF) << (16 * lo[1]));
    end
    return d;
  endfunction

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] lo);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2'b11) || (sz == 2'b01 && lo[0]) || (sz == 2'b10 && lo != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Model state: at most one request in flight; cycles counted in posedges.
  int          ecount = 0;
  logic        busy = 1'b0;
  int          hs = 0, lat = 0, ew = 0;
  logic        m_store = 1'b0, m_mis = 1'b0;
  logic [5:0]  m_idx = '0;
  logic [31:0] m_load = '0, m_word = '0, exp_data = '0;
  logic        chk_en = 1'b0;
  logic        ev_m, emw_m;

  always @(posedge CLK) begin
    ecount++;
    if (busy && m_store && !m_mis && ecount == ew + 1 && Reset_n) ref_mem[m_idx] = m_word;
    if (!Reset_n) begin
      busy = 1'b0;
      exp_data = '0;
    end else if (busy) begin
      if (ecount == hs + lat - 1) exp_data = m_store ? 32'h0 : m_load;
      if (ecount == hs + lat) busy = 1'b0;
    end else if (ReqValid) begin
      hs      = ecount;
      m_idx   = ReqAddr[7:2];
      m_store = ReqWrite;
      m_mis   = is_mis(ReqSize, ReqAddr[1:0]);
      m_load  = ext_load(ref_mem[m_idx], ReqSize, ReqSigned, ReqAddr[1:0]);
      m_word  = store_word(ref_mem[m_idx], ReqSize, ReqAddr[1:0], ReqWData);
      lat     = m_mis ? 1 : ((ReqWrite && ReqSize < 2'd2) ? 3 : 2);
      ew      = (lat == 3) ? hs + 1 : hs;
      busy    = 1'b1;
      if (m_mis) exp_data = '0;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      ev_m  = busy && (ecount == hs + lat - 1);
      emw_m = busy && m_store && !m_mis && (ecount == ew) && Reset_n;
      chkb("ReqReady", ReqReady, !busy);
      chkb("RespValid", RespValid, ev_m);
      chkb("RespErr", RespErr, ev_m && m_mis);
      chk("RespData", RespData, exp_data);
      chkb("MemWrite", MemWrite, emw_m);
      if (emw_m) begin
        chk("MemAddr", {26'h0, MemAddr}, {26'h0, m_idx});
        chk("MemWData", MemWData, m_word);
      end
    end
  end

  int hs_e = 0;

  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    logic ok;
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = d;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (ReqReady) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL handshake: ReqReady never 1 for addr %h", a);
    end
    @(posedge CLK);
    #2;
    ReqValid = 1'b0;
    hs_e = ecount;
  endtask

  task automatic wait_resp(input string nm, input logic [31:0] exp_d, input int exp_lat,
                           input logic exp_err);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (RespValid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errs++;
      $display("FAIL %s: RespValid never 1", nm);
    end else begin
      chk({nm, " data"}, RespData, exp_d);
      chk({nm, " latency"}, ecount - hs_e + 1, exp_lat);
      chkb({nm, " err"}, RespErr, exp_err);
    end
  endtask

  int hs1;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = i * 32'h1111_1111;
    mem[5] = 32'h8899_AABB;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge CLK);
    #2;
    @(negedge CLK);
    chkb("reset ReqReady", ReqReady, 1'b1);
    chkb("reset RespValid", RespValid, 1'b0);
    chk("reset RespData", RespData, 32'h0);
    chkb("reset RespErr", RespErr, 1'b0);
    chkb("reset MemWrite", MemWrite, 1'b0);
    @(posedge CLK);
    #2;
    Reset_n = 1'b1;
    chk_en = 1'b1;

    req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);  wait_resp("ld word", 32'h8899_AABB, 2, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h17, 32'h0);  wait_resp("ld sbyte", 32'hFFFF_FF88, 2, 1'b0);
    req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0);  wait_resp("ld ubyte", 32'h0000_00AA, 2, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0);  wait_resp("ld shalf", 32'hFFFF_8899, 2, 1'b0);
    req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_1234); wait_resp("st half", 32'h0, 3, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);  wait_resp("ld after st", 32'h1234_AABB, 2, 1'b0);

    // Two back-to-back requests with ReqValid held high.
    req(1'b0, 2'b10, 1'b0, 32'h114, 32'h0);
    hs1 = hs_e;
    req(1'b0, 2'b01, 1'b0, 32'h116, 32'h0);
    chk("queued spacing", hs_e - hs1, 3);
    wait_resp("ld uhalf wrap", 32'h0000_1234, 2, 1'b0);

    // Reset during the MERGE cycle of a byte store.
    req(1'b1, 2'b00, 1'b0, 32'h14, 32'h55);
    @(posedge CLK);
    #2;
    Reset_n = 1'b0;
    @(negedge CLK);
    chkb("abort MemWrite", MemWrite, 1'b0);
    @(posedge CLK);
    #2;
    Reset_n = 1'b1;
    @(negedge CLK);
    chkb("abort ReqReady", ReqReady, 1'b1);
    chkb("abort RespValid", RespValid, 1'b0);
    repeat (2) @(negedge CLK);
    chk("abort mem", mem[5], 32'h1234_AABB);

    req(1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    wait_resp("ld word mis", 32'h0, 1, 1'b1);
`else
    wait_resp("ld word mis", 32'h1234_AABB, 2, 1'b0);
`endif

    req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF); wait_resp("st word", 32'h0, 2, 1'b0);
    req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);  wait_resp("ld shalf hi", 32'hFFFF_DEAD, 2, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h21, 32'h7F); wait_resp("st byte", 32'h0, 3, 1'b0);
    req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);  wait_resp("ld word 8", 32'hDEAD_7FEF, 2, 1'b0);
    req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);  wait_resp("ld uhalf lo", 32'h0000_7FEF, 2, 1'b0);
    req(1'b1, 2'b00, 1'b0, 32'h23, 32'hA5); wait_resp("st byte3", 32'h0, 3, 1'b0);
    req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);  wait_resp("ld sbyte3", 32'hFFFF_FFA5, 2, 1'b0);
    req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    wait_resp("ld rsvd", 32'h0, 1, 1'b1);
`else
    wait_resp("ld rsvd", 32'hA5AD_7FEF, 2, 1'b0);
`endif
    chk("mem word 8", mem[8], 32'hA5AD_7FEF);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

endmodule
